// File: rtl/bsg_cache_to_dram_ctrl_pkg.sv
// rtl/bsg_cache_to_dram_ctrl_pkg.sv - shared types and helpers for the cache-to-DRAM controller
package bsg_cache_to_dram_ctrl_pkg;

    typedef enum logic [0:0] {
        e_tx_arb_idle,
        e_tx_arb_burst
    } tx_arb_state_e;

    // Width of an index into x items; never zero so single-item configs still get a port.
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_cache_to_dram_ctrl_tx_rr_pick.sv
// rtl/bsg_cache_to_dram_ctrl_tx_rr_pick.sv - first valid port at or after rr_ptr, cyclically
module bsg_cache_to_dram_ctrl_tx_rr_pick #(
    parameter int num_p = 2,
    parameter int lg_p  = 1
) (
    input  logic [num_p-1:0] v_i,
    input  logic [lg_p-1:0]  rr_ptr_i,
    output logic             found_o,
    output logic [lg_p-1:0]  id_o
);

    int              w_idx;
    logic [lg_p-1:0] w_cand;

    // Scan from the farthest offset down so the port nearest rr_ptr is written last and wins.
    always_comb begin
        found_o = 1'b0;
        id_o    = rr_ptr_i;
        w_idx   = 0;
        w_cand  = '0;
        for (int i = num_p - 1; i >= 0; i--) begin
            w_idx = int'(rr_ptr_i) + i;
            if (w_idx >= num_p) begin
                w_idx = w_idx - num_p;
            end
            w_cand = lg_p'(w_idx);
            if (v_i[w_cand]) begin
                found_o = 1'b1;
                id_o    = w_cand;
            end
        end
    end

endmodule

// File: rtl/bsg_mux.sv
// rtl/bsg_mux.sv - select one of els_p words of width_p bits
module bsg_mux #(
    parameter int width_p  = 8,
    parameter int els_p    = 2,
    parameter int lg_els_p = 1
) (
    input  logic [els_p-1:0][width_p-1:0] data_i,
    input  logic [lg_els_p-1:0]           sel_i,
    output logic [width_p-1:0]            data_o
);

    assign data_o = data_i[sel_i];

endmodule

// File: rtl/bsg_cache_to_dram_ctrl_tx_arb.sv
// rtl/bsg_cache_to_dram_ctrl_tx_arb.sv - burst-locked round-robin arbiter for the DMA write-data path
module bsg_cache_to_dram_ctrl_tx_arb
    import bsg_cache_to_dram_ctrl_pkg::*;
#(
    parameter int num_dma_p        = 2,
    parameter int dma_data_width_p = 16,
    parameter int dma_mask_width_p = 4,
    parameter int dma_burst_len_p  = 4,
    parameter int lg_num_dma_lp    = safe_clog2(num_dma_p)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [num_dma_p*dma_data_width_p-1:0] dma_data_i,
    input  logic [num_dma_p*dma_mask_width_p-1:0] dma_mask_i,
    input  logic [num_dma_p-1:0]                  dma_data_v_i,
    output logic [num_dma_p-1:0]                  dma_data_yumi_o,
    output logic                                  tx_data_v_o,
    output logic [dma_data_width_p-1:0]           tx_data_o,
    output logic [dma_mask_width_p-1:0]           tx_mask_o,
    input  logic                                  tx_data_yumi_i,
    output logic [lg_num_dma_lp-1:0]              grant_id_o,
    output logic                                  busy_o
);

    localparam int                      cnt_w_lp     = $clog2(dma_burst_len_p + 1);
    localparam logic [cnt_w_lp-1:0]     last_beat_lp = cnt_w_lp'(dma_burst_len_p - 1);
    localparam logic [lg_num_dma_lp-1:0] max_id_lp   = lg_num_dma_lp'(num_dma_p - 1);

    tx_arb_state_e            r_state, w_state_nxt;
    logic [cnt_w_lp-1:0]      r_beat_cnt, w_beat_cnt_nxt;
    logic [lg_num_dma_lp-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [lg_num_dma_lp-1:0] r_grant, w_grant_nxt;

    logic                     w_found;
    logic [lg_num_dma_lp-1:0] w_pick_id;
    logic [lg_num_dma_lp-1:0] w_sel;
    logic [lg_num_dma_lp-1:0] w_next_ptr;
    logic                     w_xfer;

    bsg_cache_to_dram_ctrl_tx_rr_pick #(
        .num_p (num_dma_p),
        .lg_p  (lg_num_dma_lp)
    ) u_rr_pick (
        .v_i      (dma_data_v_i),
        .rr_ptr_i (r_rr_ptr),
        .found_o  (w_found),
        .id_o     (w_pick_id)
    );

    // While locked the owner keeps the grant even with v low, so a gap becomes a bubble.
    always_comb begin
        w_sel = r_rr_ptr;
        if (r_state == e_tx_arb_burst) begin
            w_sel = r_grant;
        end else if (w_found) begin
            w_sel = w_pick_id;
        end
    end

    assign grant_id_o  = reset_n_i ? w_sel : '0;
    assign tx_data_v_o = reset_n_i & dma_data_v_i[w_sel];
    assign busy_o      = reset_n_i & (r_state == e_tx_arb_burst);
    assign w_xfer      = tx_data_yumi_i & tx_data_v_o;
    assign w_next_ptr  = (w_sel == max_id_lp) ? '0 : w_sel + 1'b1;

    always_comb begin
        dma_data_yumi_o = '0;
        if (w_xfer) begin
            dma_data_yumi_o[w_sel] = 1'b1;
        end
    end

    bsg_mux #(
        .width_p  (dma_data_width_p),
        .els_p    (num_dma_p),
        .lg_els_p (lg_num_dma_lp)
    ) u_data_mux (
        .data_i (dma_data_i),
        .sel_i  (grant_id_o),
        .data_o (tx_data_o)
    );

    bsg_mux #(
        .width_p  (dma_mask_width_p),
        .els_p    (num_dma_p),
        .lg_els_p (lg_num_dma_lp)
    ) u_mask_mux (
        .data_i (dma_mask_i),
        .sel_i  (grant_id_o),
        .data_o (tx_mask_o)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_grant_nxt    = r_grant;
        case (r_state)
            e_tx_arb_idle: begin
                if (w_xfer) begin
                    if (dma_burst_len_p > 1) begin
                        w_state_nxt    = e_tx_arb_burst;
                        w_grant_nxt    = w_sel;
                        w_beat_cnt_nxt = cnt_w_lp'(1);
                    end else begin
                        w_rr_ptr_nxt = w_next_ptr;
                    end
                end
            end
            e_tx_arb_burst: begin
                if (w_xfer) begin
                    if (r_beat_cnt == last_beat_lp) begin
                        w_state_nxt    = e_tx_arb_idle;
                        w_beat_cnt_nxt = '0;
                        w_rr_ptr_nxt   = w_next_ptr;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = e_tx_arb_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= e_tx_arb_idle;
            r_beat_cnt <= '0;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_grant    <= w_grant_nxt;
        end
    end

endmodule

// File: tb/tb_bsg_cache_to_dram_ctrl_tx_arb.sv
// tb/tb_bsg_cache_to_dram_ctrl_tx_arb.sv - self-checking bench for the burst-locked tx arbiter
module tb_bsg_cache_to_dram_ctrl_tx_arb;

    localparam int NA = 2, WA = 16, MA = 4, LA = 4;
    localparam int NB = 3, WB = 8,  MB = 2, LB = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NA*WA-1:0] data_a;
    logic [NA*MA-1:0] mask_a;
    logic [NA-1:0]    v_a, yumi_a;
    logic             tx_v_a, tx_yumi_a, busy_a;
    logic [WA-1:0]    tx_data_a;
    logic [MA-1:0]    tx_mask_a;
    logic [0:0]       grant_a;

    logic [NB*WB-1:0] data_b;
    logic [NB*MB-1:0] mask_b;
    logic [NB-1:0]    v_b, yumi_b;
    logic             tx_v_b, tx_yumi_b, busy_b;
    logic [WB-1:0]    tx_data_b;
    logic [MB-1:0]    tx_mask_b;
    logic [1:0]       grant_b;

    bsg_cache_to_dram_ctrl_tx_arb #(
        .num_dma_p(NA), .dma_data_width_p(WA), .dma_mask_width_p(MA), .dma_burst_len_p(LA)
    ) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .dma_data_i(data_a), .dma_mask_i(mask_a),
        .dma_data_v_i(v_a), .dma_data_yumi_o(yumi_a), .tx_data_v_o(tx_v_a),
        .tx_data_o(tx_data_a), .tx_mask_o(tx_mask_a), .tx_data_yumi_i(tx_yumi_a),
        .grant_id_o(grant_a), .busy_o(busy_a)
    );

    bsg_cache_to_dram_ctrl_tx_arb #(
        .num_dma_p(NB), .dma_data_width_p(WB), .dma_mask_width_p(MB), .dma_burst_len_p(LB)
    ) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .dma_data_i(data_b), .dma_mask_i(mask_b),
        .dma_data_v_i(v_b), .dma_data_yumi_o(yumi_b), .tx_data_v_o(tx_v_b),
        .tx_data_o(tx_data_b), .tx_mask_o(tx_mask_b), .tx_data_yumi_i(tx_yumi_b),
        .grant_id_o(grant_b), .busy_o(busy_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner = port holding the burst lock (-1 when free), done = words it has sent.
    typedef struct {
        int owner;
        int done;
        int rr;
    } mstate_t;

    mstate_t ms[2] = '{'{-1, 0, 0}, '{-1, 0, 0}};
    int      mn[2] = '{NA, NB};
    int      ml[2] = '{LA, LB};

    function automatic int mgrant(input int k, input logic [2:0] v);
        int p;
        if (ms[k].owner >= 0) return ms[k].owner;
        for (int o = 0; o < mn[k]; o++) begin
            p = (ms[k].rr + o) % mn[k];
            if (v[p]) return p;
        end
        return ms[k].rr;
    endfunction

    function automatic mstate_t mnext(input int k, input logic [2:0] v, input logic ty);
        mstate_t s;
        int      g;
        s = ms[k];
        g = mgrant(k, v);
        if (ty && v[g]) begin
            if (s.owner < 0 && ml[k] > 1) begin
                s.owner = g;
                s.done  = 1;
            end else if (s.owner < 0 || s.done + 1 == ml[k]) begin
                s.owner = -1;
                s.done  = 0;
                s.rr    = (g + 1) % mn[k];
            end else begin
                s.done = s.done + 1;
            end
        end
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms[0] <= '{-1, 0, 0};
            ms[1] <= '{-1, 0, 0};
        end else begin
            ms[0] <= mnext(0, {1'b0, v_a}, tx_yumi_a);
            ms[1] <= mnext(1, v_b, tx_yumi_b);
        end
    end

    always @(negedge clk) begin
        int g, ev;
        g  = rst_n ? mgrant(0, {1'b0, v_a}) : 0;
        ev = rst_n ? int'(v_a[g]) : 0;
        chk("a_tx_v", 32'(tx_v_a), 32'(ev));
        chk("a_yumi", 32'(yumi_a), (tx_yumi_a && ev != 0) ? (32'd1 << g) : 32'd0);
        chk("a_grant", 32'(grant_a), 32'(g));
        chk("a_busy", 32'(busy_a), 32'(rst_n && ms[0].owner >= 0));
        if (ev != 0) begin
            chk("a_data", 32'(tx_data_a), 32'(data_a[g*WA +: WA]));
            chk("a_mask", 32'(tx_mask_a), 32'(mask_a[g*MA +: MA]));
        end
        g  = rst_n ? mgrant(1, v_b) : 0;
        ev = rst_n ? int'(v_b[g]) : 0;
        chk("b_tx_v", 32'(tx_v_b), 32'(ev));
        chk("b_yumi", 32'(yumi_b), (tx_yumi_b && ev != 0) ? (32'd1 << g) : 32'd0);
        chk("b_grant", 32'(grant_b), 32'(g));
        chk("b_busy", 32'(busy_b), 32'd0);
        if (ev != 0) begin
            chk("b_data", 32'(tx_data_b), 32'(data_b[g*WB +: WB]));
            chk("b_mask", 32'(tx_mask_b), 32'(mask_b[g*MB +: MB]));
        end
    end

    int t2_grant[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int t2_busy[9]  = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
    int t6_grant[4] = '{0, 1, 2, 0};

    task automatic new_data();
        data_a = {$urandom, $urandom};
        mask_a = 8'($urandom);
        data_b = 24'($urandom);
        mask_b = 6'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        new_data();
    endtask

    initial begin
        rst_n     = 1'b0;
        v_a       = 2'b11;
        v_b       = 3'b111;
        tx_yumi_a = 1'b1;
        tx_yumi_b = 1'b1;
        new_data();

        // Reset holds everything quiet even with valid requests and yumi asserted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_v", 32'(tx_v_a), 32'd0);
        chk("rst_yumi", 32'(yumi_a), 32'd0);
        chk("rst_grant", 32'(grant_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_yumi_b", 32'(yumi_b), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("t2_grant", 32'(grant_a), 32'(t2_grant[i]));
            chk("t2_busy", 32'(busy_a), 32'(t2_busy[i]));
            chk("t2_yumi", 32'(yumi_a), 32'd1 << t2_grant[i]);
            if (i < 4) begin
                chk("t6_grant", 32'(grant_b), 32'(t6_grant[i]));
                chk("t6_busy", 32'(busy_b), 32'd0);
            end
            tick();
        end

        // Owner port 0 drops valid after its second word; port 1 must not steal.
        @(negedge clk);
        chk("t3_w2", 32'(yumi_a), 32'd1);
        tick();
        v_a = 2'b10;
        repeat (2) begin
            @(negedge clk);
            chk("t3_gap_tx_v", 32'(tx_v_a), 32'd0);
            chk("t3_gap_yumi", 32'(yumi_a), 32'd0);
            chk("t3_gap_grant", 32'(grant_a), 32'd0);
            tick();
        end
        v_a = 2'b11;
        repeat (2) begin
            @(negedge clk);
            chk("t3_tail", 32'(yumi_a), 32'd1);
            tick();
        end
        @(negedge clk);
        chk("t3_next_grant", 32'(grant_a), 32'd1);
        chk("t3_next_yumi", 32'(yumi_a), 32'd2);
        tick();

        // Consumer stalls mid-burst of port 1.
        @(negedge clk);
        chk("t4_w2", 32'(yumi_a), 32'd2);
        tick();
        tx_yumi_a = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t4_stall_busy", 32'(busy_a), 32'd1);
            chk("t4_stall_grant", 32'(grant_a), 32'd1);
            chk("t4_stall_yumi", 32'(yumi_a), 32'd0);
            tick();
        end
        tx_yumi_a = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("t4_tail", 32'(yumi_a), 32'd2);
            tick();
        end
        @(negedge clk);
        chk("t4_done_busy", 32'(busy_a), 32'd0);
        chk("t4_done_grant", 32'(grant_a), 32'd0);
        tick();

        // Finish port 0, give port 1 two words, then reset mid-burst.
        repeat (3) tick();
        @(negedge clk);
        chk("t5_pre_grant", 32'(grant_a), 32'd1);
        tick();
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_tx_v", 32'(tx_v_a), 32'd0);
        chk("t5_rst_busy", 32'(busy_a), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_after_grant", 32'(grant_a), 32'd0);
        chk("t5_after_busy", 32'(busy_a), 32'd0);
        chk("t5_after_yumi", 32'(yumi_a), 32'd1);
        tick();

        // Random traffic: mostly-valid ports, intermittent yumi, rare resets.
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 399) != 0);
            v_a[0]    = ($urandom_range(0, 3) != 0);
            v_a[1]    = ($urandom_range(0, 3) != 0);
            v_b       = 3'($urandom);
            tx_yumi_a = ($urandom_range(0, 2) != 0);
            tx_yumi_b = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
